// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus field positions, cause codes and address-decode helpers
// for the machine-mode CSR file.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;

  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
      CSR_MINSTRETH, CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
      CSR_MHARTID: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  // misa and mip are read-only despite living in the read/write address range.
  function automatic logic csr_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11) || (addr == CSR_MISA) || (addr == CSR_MIP);
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access port between the core (master) and the CSR file (slave).
// Read data and the illegal flag are combinational responses to the request fields.
interface csr_if;
  logic        csr;
  logic [11:0] csr_rd_addr;
  logic [2:0]  csr_funct;
  logic        csr_src_zero;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        csr_illegal;

  modport master (
    output csr, csr_rd_addr, csr_funct, csr_src_zero, csr_wr_data,
    input  csr_rd_data, csr_illegal
  );

  modport slave (
    input  csr, csr_rd_addr, csr_funct, csr_src_zero, csr_wr_data,
    output csr_rd_data, csr_illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and per-half write ports; value updates one edge after inputs.
// A write to either half wins over the increment for that cycle and never carries into the other half.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] value
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo) cnt_d[31:0] = wr_data;
    if (wr_hi) cnt_d[63:32] = wr_data;
    if (!(wr_lo || wr_hi) && inc) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: zero-latency read mux, writes/trap/mret state visible from the next cycle.
// No backpressure: every access, trap and mret is accepted in the cycle it is presented.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  csr_if.slave        bus,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        instr_retire,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  logic [11:0] addr;
  logic        wr_en;
  logic        wr_ok;
  logic        unused_funct;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mie_en_q, mie_en_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [31:0] rd_data;

  assign addr         = bus.csr_rd_addr;
  assign unused_funct = ^{bus.csr_funct[2], bus.csr_funct[0]};

  // funct[1] selects the set/clear forms, which never write when the source is zero.
  assign wr_en = bus.csr & ~trap & ~(bus.csr_funct[1] & bus.csr_src_zero);
  assign wr_ok = wr_en & csr_implemented(addr) & ~csr_read_only(addr);
  assign bus.csr_illegal = bus.csr & (~csr_implemented(addr) | (wr_en & (addr[11:10] == 2'b11)));

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mie_en_d   = mie_en_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (wr_ok) begin
      case (addr)
        CSR_MSTATUS: begin
          mie_d  = bus.csr_wr_data[MSTATUS_MIE];
          mpie_d = bus.csr_wr_data[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_en_d   = bus.csr_wr_data & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = bus.csr_wr_data & ~32'h3;
        CSR_MSCRATCH: mscratch_d = bus.csr_wr_data;
        CSR_MEPC:     mepc_d     = bus.csr_wr_data & ~32'h3;
        CSR_MCAUSE:   mcause_d   = bus.csr_wr_data;
        CSR_MTVAL:    mtval_d    = bus.csr_wr_data;
        default: ;
      endcase
    end
    if (trap) begin
      mepc_d   = trap_pc & ~32'h3;
      mcause_d = trap_cause;
      mtval_d  = trap_val;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_en_q   <= '0;
      mtvec_q    <= RESET_MTVEC & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mie_en_q   <= mie_en_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc     (1'b1),
    .wr_lo   (wr_ok && (addr == CSR_MCYCLE)),
    .wr_hi   (wr_ok && (addr == CSR_MCYCLEH)),
    .wr_data (bus.csr_wr_data),
    .value   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc     (instr_retire),
    .wr_lo   (wr_ok && (addr == CSR_MINSTRET)),
    .wr_hi   (wr_ok && (addr == CSR_MINSTRETH)),
    .wr_data (bus.csr_wr_data),
    .value   (minstret)
  );

  always_comb begin
    rd_data = '0;
    case (addr)
      CSR_MSTATUS: begin
        rd_data[MSTATUS_MIE]                   = mie_q;
        rd_data[MSTATUS_MPIE]                  = mpie_q;
        rd_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MISA:                   rd_data = MISA_VAL;
      CSR_MIE:                    rd_data = mie_en_q;
      CSR_MTVEC:                  rd_data = mtvec_q;
      CSR_MSCRATCH:               rd_data = mscratch_q;
      CSR_MEPC:                   rd_data = mepc_q;
      CSR_MCAUSE:                 rd_data = mcause_q;
      CSR_MTVAL:                  rd_data = mtval_q;
      CSR_MCYCLE, CSR_CYCLE:      rd_data = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:    rd_data = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rd_data = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_data = minstret[63:32];
      CSR_MHARTID:                rd_data = HART_ID;
      default:                    rd_data = '0;
    endcase
  end

  assign bus.csr_rd_data = rd_data;
  assign mtvec_out       = mtvec_q;
  assign mepc_out        = mepc_q;
  assign mie_global      = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic against
// an architectural model of the machine-mode CSR state.
module tb_csr_file;
  import csr_pkg::*;

  logic        clk;
  logic        reset;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_val;
  logic        mret;
  logic        instr_retire;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mie_global;

  csr_if bus ();

  csr_file #(
    .HART_ID     (32'd0),
    .RESET_MTVEC (32'h0000_0100),
    .MISA_VAL    (32'h4000_0100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .trap         (trap),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause),
    .trap_val     (trap_val),
    .mret         (mret),
    .instr_retire (instr_retire),
    .mtvec_out    (mtvec_out),
    .mepc_out     (mepc_out),
    .mie_global   (mie_global)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural state as the core would see it.
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_en, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] impl_addrs [$] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                  12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14};
  logic [11:0] extra_addrs [$] = '{12'h7C0, 12'h345, 12'hB01, 12'hC01, 12'h000, 12'hF15};
  logic [2:0]  functs [$] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  function automatic logic m_impl(input logic [11:0] a);
    foreach (impl_addrs[i]) if (impl_addrs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_en;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_we();
    return bus.csr && !trap && !(bus.csr_funct[1] && bus.csr_src_zero);
  endfunction

  function automatic logic m_illegal();
    return bus.csr && (!m_impl(bus.csr_rd_addr) || (m_we() && (bus.csr_rd_addr >= 12'hC00)));
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mie_en = 0; m_mtvec = 32'h100; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
  endtask

  task automatic model_update();
    logic        old_mie, old_mpie;
    logic [63:0] cyc, ins;
    logic [31:0] wd;
    old_mie = m_mie; old_mpie = m_mpie;
    cyc = m_cycle + 64'd1;
    ins = m_instret + (instr_retire ? 64'd1 : 64'd0);
    wd  = bus.csr_wr_data;
    if (m_we()) begin
      case (bus.csr_rd_addr)
        12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
        12'h304: m_mie_en = wd & 32'h888;
        12'h305: m_mtvec = wd & ~32'h3;
        12'h340: m_mscratch = wd;
        12'h341: m_mepc = wd & ~32'h3;
        12'h342: m_mcause = wd;
        12'h343: m_mtval = wd;
        12'hB00: cyc = {m_cycle[63:32], wd};
        12'hB80: cyc = {wd, m_cycle[31:0]};
        12'hB02: ins = {m_instret[63:32], wd};
        12'hB82: ins = {wd, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = cyc;
    m_instret = ins;
    if (trap) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_val;
      m_mpie = old_mie; m_mie = 0;
    end else if (mret) begin
      m_mie = old_mpie; m_mpie = 1;
    end
  endtask

  // Advance one clock: the model commits with the same inputs the DUT sees.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.csr = 0; bus.csr_rd_addr = 0; bus.csr_funct = 0; bus.csr_src_zero = 0;
    bus.csr_wr_data = 0; trap = 0; trap_pc = 0; trap_cause = 0; trap_val = 0;
    mret = 0; instr_retire = 0;
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [2:0] f, input logic sz, input logic [31:0] wd);
    bus.csr = 1; bus.csr_rd_addr = a; bus.csr_funct = f; bus.csr_src_zero = sz; bus.csr_wr_data = wd;
  endtask

  task automatic rd(input logic [11:0] a);
    bus.csr_rd_addr = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    repeat (3) cycle();
    reset = 0;
    rd(12'h305);
    checks++; if (bus.csr_rd_data !== 32'h100) begin errors++; $display("FAIL reset_mtvec got %h exp %h", bus.csr_rd_data, 32'h100); end
    rd(12'h301);
    checks++; if (bus.csr_rd_data !== 32'h4000_0100) begin errors++; $display("FAIL reset_misa got %h exp %h", bus.csr_rd_data, 32'h4000_0100); end
    rd(12'hF14);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL reset_mhartid got %h exp 0", bus.csr_rd_data); end
    rd(12'hB00);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL reset_mcycle got %h exp 0", bus.csr_rd_data); end
    checks++; if (mie_global !== 1'b0) begin errors++; $display("FAIL reset_mie_global got %b exp 0", mie_global); end
    checks++; if (mtvec_out !== 32'h100) begin errors++; $display("FAIL reset_mtvec_out got %h exp %h", mtvec_out, 32'h100); end
    rd(12'h300);
    checks++; if (bus.csr_rd_data !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", bus.csr_rd_data, 32'h1800); end
  endtask

  task automatic test_write();
    logic [31:0] junk;
    junk = $urandom;
    set_csr(12'h340, 3'b001, 1'b0, 32'hDEAD_BEEF);
    #1;
    checks++; if (bus.csr_illegal !== 1'b0) begin errors++; $display("FAIL rw_illegal got %b exp 0", bus.csr_illegal); end
    cycle(); idle(); rd(12'h340);
    checks++; if (bus.csr_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL csrrw_mscratch got %h exp %h", bus.csr_rd_data, 32'hDEAD_BEEF); end
    set_csr(12'h340, 3'b010, 1'b1, 32'h0);
    cycle(); idle(); rd(12'h340);
    checks++; if (bus.csr_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL csrrs_zero got %h exp %h", bus.csr_rd_data, 32'hDEAD_BEEF); end
    set_csr(12'h340, 3'b111, 1'b1, junk);
    cycle(); idle(); rd(12'h340);
    checks++; if (bus.csr_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL csrrci_zero got %h exp %h", bus.csr_rd_data, 32'hDEAD_BEEF); end
    set_csr(12'h304, 3'b001, 1'b0, 32'hFFFF_FFFF);
    cycle(); idle(); rd(12'h304);
    checks++; if (bus.csr_rd_data !== 32'h888) begin errors++; $display("FAIL mie_mask got %h exp %h", bus.csr_rd_data, 32'h888); end
  endtask

  task automatic test_trap_mret();
    logic [31:0] tv, pc2;
    tv = $urandom; pc2 = $urandom;
    set_csr(12'h300, 3'b001, 1'b0, 32'h8);
    cycle(); idle(); rd(12'h300);
    checks++; if (bus.csr_rd_data !== 32'h1808) begin errors++; $display("FAIL mstatus_set got %h exp %h", bus.csr_rd_data, 32'h1808); end
    trap = 1; trap_pc = 32'h123; trap_cause = MCAUSE_BREAKPOINT; trap_val = tv;
    cycle(); idle();
    #1;
    checks++; if (mepc_out !== 32'h120) begin errors++; $display("FAIL trap_mepc got %h exp %h", mepc_out, 32'h120); end
    checks++; if (mie_global !== 1'b0) begin errors++; $display("FAIL trap_mie got %b exp 0", mie_global); end
    rd(12'h342);
    checks++; if (bus.csr_rd_data !== 32'd3) begin errors++; $display("FAIL trap_mcause got %h exp 3", bus.csr_rd_data); end
    rd(12'h343);
    checks++; if (bus.csr_rd_data !== tv) begin errors++; $display("FAIL trap_mtval got %h exp %h", bus.csr_rd_data, tv); end
    rd(12'h300);
    checks++; if (bus.csr_rd_data !== 32'h1880) begin errors++; $display("FAIL trap_mstatus got %h exp %h", bus.csr_rd_data, 32'h1880); end
    mret = 1;
    cycle(); idle(); rd(12'h300);
    checks++; if (bus.csr_rd_data !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp %h", bus.csr_rd_data, 32'h1888); end
    checks++; if (mie_global !== 1'b1) begin errors++; $display("FAIL mret_mie got %b exp 1", mie_global); end
    trap = 1; mret = 1; trap_pc = pc2; trap_cause = MCAUSE_ECALL_M; trap_val = 0;
    cycle(); idle(); rd(12'h300);
    checks++; if (bus.csr_rd_data !== 32'h1880) begin errors++; $display("FAIL trap_beats_mret got %h exp %h", bus.csr_rd_data, 32'h1880); end
    checks++; if (mepc_out !== (pc2 & ~32'h3)) begin errors++; $display("FAIL ecall_mepc got %h exp %h", mepc_out, pc2 & ~32'h3); end
    rd(12'h342);
    checks++; if (bus.csr_rd_data !== 32'd11) begin errors++; $display("FAIL ecall_mcause got %h exp 11", bus.csr_rd_data); end
  endtask

  task automatic test_counters();
    logic [31:0] hx, l0;
    hx = $urandom;
    set_csr(12'hB80, 3'b001, 1'b0, 32'h0);
    cycle();
    set_csr(12'hB00, 3'b001, 1'b0, 32'hFFFF_FFFF);
    cycle(); idle(); rd(12'hB00);
    checks++; if (bus.csr_rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_write got %h exp %h", bus.csr_rd_data, 32'hFFFF_FFFF); end
    cycle(); rd(12'hB80);
    checks++; if (bus.csr_rd_data !== 32'h1) begin errors++; $display("FAIL mcycle_carry_hi got %h exp 1", bus.csr_rd_data); end
    rd(12'hB00);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_lo got %h exp 0", bus.csr_rd_data); end
    rd(12'hC80);
    checks++; if (bus.csr_rd_data !== 32'h1) begin errors++; $display("FAIL cycleh_shadow got %h exp 1", bus.csr_rd_data); end
    cycle();
    l0 = m_cycle[31:0];
    set_csr(12'hB80, 3'b001, 1'b0, hx);
    cycle(); idle(); rd(12'hB00);
    checks++; if (bus.csr_rd_data !== l0) begin errors++; $display("FAIL mcycleh_wr_lo_hold got %h exp %h", bus.csr_rd_data, l0); end
    rd(12'hB80);
    checks++; if (bus.csr_rd_data !== hx) begin errors++; $display("FAIL mcycleh_wr got %h exp %h", bus.csr_rd_data, hx); end
    cycle(); rd(12'hB00);
    checks++; if (bus.csr_rd_data !== l0 + 32'd1) begin errors++; $display("FAIL mcycle_resume got %h exp %h", bus.csr_rd_data, l0 + 32'd1); end
    // minstret: write beats a simultaneous retire, then the next retire carries.
    set_csr(12'hB02, 3'b001, 1'b0, 32'hFFFF_FFFF); instr_retire = 1;
    cycle(); idle(); instr_retire = 1; rd(12'hB02);
    checks++; if (bus.csr_rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL minstret_write got %h exp %h", bus.csr_rd_data, 32'hFFFF_FFFF); end
    cycle(); instr_retire = 0; rd(12'hB82);
    checks++; if (bus.csr_rd_data !== m_read(12'hB82)) begin errors++; $display("FAIL minstret_carry got %h exp %h", bus.csr_rd_data, m_read(12'hB82)); end
    rd(12'hC02);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL instret_wrap got %h exp 0", bus.csr_rd_data); end
    cycle(); rd(12'hB02);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL minstret_idle got %h exp 0", bus.csr_rd_data); end
  endtask

  task automatic test_illegal();
    logic [31:0] wd;
    wd = $urandom;
    set_csr(12'hC00, 3'b001, 1'b0, wd);
    #1;
    checks++; if (bus.csr_illegal !== 1'b1) begin errors++; $display("FAIL ill_write_c00 got %b exp 1", bus.csr_illegal); end
    cycle(); idle(); rd(12'hC00);
    checks++; if (bus.csr_rd_data !== m_read(12'hC00)) begin errors++; $display("FAIL ill_c00_unchanged got %h exp %h", bus.csr_rd_data, m_read(12'hC00)); end
    set_csr(12'h7C0, 3'b010, 1'b1, 32'h0);
    #1;
    checks++; if (bus.csr_illegal !== 1'b1) begin errors++; $display("FAIL ill_7c0 got %b exp 1", bus.csr_illegal); end
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL ill_7c0_data got %h exp 0", bus.csr_rd_data); end
    cycle();
    set_csr(12'hC00, 3'b010, 1'b1, 32'h0);
    #1;
    checks++; if (bus.csr_illegal !== 1'b0) begin errors++; $display("FAIL ro_read_legal got %b exp 0", bus.csr_illegal); end
    cycle();
    set_csr(12'hF14, 3'b101, 1'b0, wd);
    #1;
    checks++; if (bus.csr_illegal !== 1'b1) begin errors++; $display("FAIL ill_mhartid_wr got %b exp 1", bus.csr_illegal); end
    cycle();
    set_csr(12'h301, 3'b001, 1'b0, wd);
    #1;
    checks++; if (bus.csr_illegal !== 1'b0) begin errors++; $display("FAIL misa_wr_flag got %b exp 0", bus.csr_illegal); end
    cycle(); idle(); rd(12'h301);
    checks++; if (bus.csr_rd_data !== 32'h4000_0100) begin errors++; $display("FAIL misa_wr_dropped got %h exp %h", bus.csr_rd_data, 32'h4000_0100); end
    rd(12'hF14);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL mhartid_kept got %h exp 0", bus.csr_rd_data); end
  endtask

  task automatic test_trap_vs_csr();
    logic [31:0] pc;
    pc = $urandom;
    set_csr(12'h305, 3'b001, 1'b0, $urandom);
    trap = 1; trap_pc = pc; trap_cause = MCAUSE_ECALL_M; trap_val = 32'h55;
    #1;
    checks++; if (bus.csr_illegal !== 1'b0) begin errors++; $display("FAIL trapcsr_illegal got %b exp 0", bus.csr_illegal); end
    cycle(); idle(); #1;
    checks++; if (mtvec_out !== 32'h100) begin errors++; $display("FAIL trapcsr_mtvec got %h exp %h", mtvec_out, 32'h100); end
    checks++; if (mepc_out !== (pc & ~32'h3)) begin errors++; $display("FAIL trapcsr_mepc got %h exp %h", mepc_out, pc & ~32'h3); end
    rd(12'h343);
    checks++; if (bus.csr_rd_data !== 32'h55) begin errors++; $display("FAIL trapcsr_mtval got %h exp %h", bus.csr_rd_data, 32'h55); end
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 3) == 0) a = extra_addrs[$urandom_range(0, extra_addrs.size() - 1)];
      else a = impl_addrs[$urandom_range(0, impl_addrs.size() - 1)];
      bus.csr = ($urandom_range(0, 3) != 0);
      bus.csr_rd_addr = a;
      bus.csr_funct = functs[$urandom_range(0, functs.size() - 1)];
      bus.csr_src_zero = ($urandom_range(0, 3) == 0);
      bus.csr_wr_data = $urandom;
      trap = ($urandom_range(0, 15) == 0);
      mret = !trap && ($urandom_range(0, 15) == 0);
      trap_pc = $urandom; trap_cause = $urandom; trap_val = $urandom;
      instr_retire = $urandom_range(0, 1);
      #1;
      checks++; if (bus.csr_rd_data !== m_read(a)) begin errors++; $display("FAIL rand_rd[%0d] addr %h got %h exp %h", n, a, bus.csr_rd_data, m_read(a)); end
      checks++; if (bus.csr_illegal !== m_illegal()) begin errors++; $display("FAIL rand_ill[%0d] addr %h got %b exp %b", n, a, bus.csr_illegal, m_illegal()); end
      cycle();
      #1;
      checks++; if (mtvec_out !== m_mtvec) begin errors++; $display("FAIL rand_mtvec[%0d] got %h exp %h", n, mtvec_out, m_mtvec); end
      checks++; if (mepc_out !== m_mepc) begin errors++; $display("FAIL rand_mepc[%0d] got %h exp %h", n, mepc_out, m_mepc); end
      checks++; if (mie_global !== m_mie) begin errors++; $display("FAIL rand_mie[%0d] got %b exp %b", n, mie_global, m_mie); end
    end
    idle();
  endtask

  task automatic test_reset_mid_count();
    idle(); instr_retire = 1;
    set_csr(12'h340, 3'b001, 1'b0, 32'h1234_5678);
    cycle(); bus.csr = 0;
    repeat (5) cycle();
    reset = 1; model_reset();
    rd(12'hB00);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL midrst_mcycle got %h exp 0", bus.csr_rd_data); end
    rd(12'hB80);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL midrst_mcycleh got %h exp 0", bus.csr_rd_data); end
    rd(12'hB02);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL midrst_minstret got %h exp 0", bus.csr_rd_data); end
    rd(12'h340);
    checks++; if (bus.csr_rd_data !== 32'h0) begin errors++; $display("FAIL midrst_mscratch got %h exp 0", bus.csr_rd_data); end
    checks++; if (mtvec_out !== 32'h100) begin errors++; $display("FAIL midrst_mtvec got %h exp %h", mtvec_out, 32'h100); end
    cycle();
    reset = 0;
    cycle(); rd(12'hB00);
    checks++; if (bus.csr_rd_data !== 32'h1) begin errors++; $display("FAIL postrst_mcycle got %h exp 1", bus.csr_rd_data); end
    rd(12'hB02);
    checks++; if (bus.csr_rd_data !== 32'h1) begin errors++; $display("FAIL postrst_minstret got %h exp 1", bus.csr_rd_data); end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    model_reset();
    @(negedge clk);
    test_reset();
    test_write();
    test_trap_mret();
    test_counters();
    test_illegal();
    test_trap_vs_csr();
    test_random();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
